// File: rtl/sram_responder_if.sv
// sram_responder_if: pin bundle between a memory controller and the SRAM
// responder.
//   addr, wre, oute, hb_mask, lb_mask, chip_en : controller-driven pins (active low strobes)
//   ctl_wdata / ctl_drive : controller's contribution to the shared data bus
//   rsp_rdata / rsp_drive : responder's contribution to the shared data bus
//   data                  : resolved shared 16-bit bus, high-Z when nobody drives
interface sram_responder_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] addr;
    logic              wre;
    logic              oute;
    logic              hb_mask;
    logic              lb_mask;
    logic              chip_en;

    logic [15:0]       ctl_wdata;
    logic              ctl_drive;
    logic [15:0]       rsp_rdata;
    logic              rsp_drive;

    logic [15:0]       data;

    // Both ends' drivers are merged here so the bus has a single driver.
    assign data = rsp_drive ? rsp_rdata : (ctl_drive ? ctl_wdata : 'z);

    modport master (
        output addr, wre, oute, hb_mask, lb_mask, chip_en, ctl_wdata, ctl_drive,
        input  data, rsp_drive
    );

    modport slave (
        input  addr, wre, oute, hb_mask, lb_mask, chip_en, data,
        output rsp_rdata, rsp_drive
    );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: clocked emulation of a 16-bit asynchronous SRAM, responder
// end of the controller's RAM pin protocol, backed by inferred block RAM.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : sram_responder_if.slave (address, strobes, byte masks, shared data)
// Optional: define SRAM_ACCESS_CNT_EN to add
//   rd_count : reads that reached valid, once per address hold (32-bit, wraps)
//   wr_count : write edges with at least one lane enabled (32-bit, wraps)
module sram_responder #(
    parameter int ADDR_W   = 18,
    parameter int DEPTH_W  = 12,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    sram_responder_if.slave   bus
`ifdef SRAM_ACCESS_CNT_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    typedef enum logic [1:0] {CMD_IDLE, CMD_WRITE, CMD_READ} cmd_e;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_VALID} rd_state_e;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    cmd_e              cmd;
    cmd_e              cmd_q;
    rd_state_e         state_q, state_d;
    logic [2:0]        rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              restart;
    logic [DEPTH_W-1:0] idx;
    logic [15:0]       rd_data_q;
    logic [15:0]       mem [2**DEPTH_W];

    assign idx = bus.addr[DEPTH_W-1:0];

    always_comb begin
        cmd = CMD_IDLE;
        if (!bus.chip_en) begin
            if (!bus.wre)       cmd = CMD_WRITE;
            else if (!bus.oute) cmd = CMD_READ;
        end
    end

    always_comb begin
        restart  = 1'b0;
        rd_cnt_d = '0;
        state_d  = RD_IDLE;
        if (cmd == CMD_READ) begin
            if (cmd_q != CMD_READ || bus.addr != addr_q) begin
                restart  = 1'b1;
                rd_cnt_d = 3'd1;
            end else if (rd_cnt_q < LAT) begin
                rd_cnt_d = rd_cnt_q + 3'd1;
            end else begin
                rd_cnt_d = LAT;
            end
            state_d = (rd_cnt_d == LAT) ? RD_VALID : RD_WAIT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RD_IDLE;
            rd_cnt_q <= '0;
            addr_q   <= '0;
            cmd_q    <= CMD_IDLE;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            addr_q   <= bus.addr;
            cmd_q    <= cmd;
        end
    end

    // Writes and reads are never sampled on the same edge, and a read needs at
    // least one further edge before it is driven, so the registered read always
    // sees a committed write without an explicit bypass path.
    always_ff @(posedge clock) begin
        if (cmd == CMD_WRITE && !bus.hb_mask) mem[idx][15:8] <= bus.data[15:8];
        if (cmd == CMD_WRITE && !bus.lb_mask) mem[idx][7:0]  <= bus.data[7:0];
        rd_data_q <= mem[idx];
    end

    // Live pin terms gate the drive so the bus lets go in the same cycle the
    // controller drops the read or moves the address.
    assign bus.rsp_drive = (state_q == RD_VALID) && (cmd == CMD_READ) &&
                           (bus.addr == addr_q) && !(bus.hb_mask && bus.lb_mask);
    assign bus.rsp_rdata = {bus.hb_mask ? 8'h00 : rd_data_q[15:8],
                            bus.lb_mask ? 8'h00 : rd_data_q[7:0]};

`ifdef SRAM_ACCESS_CNT_EN
    logic [31:0] rd_count_q, wr_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            // restart covers a new hold that reaches valid on its first edge
            if (state_d == RD_VALID && (state_q != RD_VALID || restart))
                rd_count_q <= rd_count_q + 32'd1;
            if (cmd == CMD_WRITE && !(bus.hb_mask && bus.lb_mask))
                wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
    localparam int AW = 18;
    localparam int DW = 12;
    localparam int RL = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sram_responder_if #(.ADDR_W(AW)) bus_if ();

`ifdef SRAM_ACCESS_CNT_EN
    logic [31:0] rd_count, wr_count;
`endif

    sram_responder #(.ADDR_W(AW), .DEPTH_W(DW), .READ_LAT(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
`ifdef SRAM_ACCESS_CNT_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: memory image with per-lane "written" flags, plus the
    // number of consecutive edges the current read address has been held.
    logic [15:0]   m_mem [1<<DW];
    bit            m_kh  [1<<DW];
    bit            m_kl  [1<<DW];
    int            m_hold;
    logic [AW-1:0] m_last_addr;
    bit            m_last_rd;
    int unsigned   m_rd_cnt, m_wr_cnt;

    function automatic int pin_cmd();
        if (bus_if.chip_en) return 0;
        if (!bus_if.wre)    return 1;
        if (!bus_if.oute)   return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_hold      = 0;
        m_last_rd   = 0;
        m_last_addr = '0;
        m_rd_cnt    = 0;
        m_wr_cnt    = 0;
    endtask

    task automatic model_edge();
        int c;
        int idx;
        c   = pin_cmd();
        idx = int'(bus_if.addr % (1 << DW));
        if (c == 1) begin
            if (!bus_if.hb_mask) begin
                m_mem[idx][15:8] = bus_if.ctl_wdata[15:8];
                m_kh[idx] = 1;
            end
            if (!bus_if.lb_mask) begin
                m_mem[idx][7:0] = bus_if.ctl_wdata[7:0];
                m_kl[idx] = 1;
            end
            if (!(bus_if.hb_mask && bus_if.lb_mask)) m_wr_cnt++;
        end
        if (c == 2) begin
            if (m_last_rd && bus_if.addr == m_last_addr) m_hold++;
            else m_hold = 1;
            if (m_hold == RL) m_rd_cnt++;
        end else begin
            m_hold = 0;
        end
        m_last_rd   = (c == 2);
        m_last_addr = bus_if.addr;
    endtask

    task automatic check_bus(input string tag);
        bit          exp_drv;
        bit          known;
        int          idx;
        logic [15:0] exp_data;
        idx     = int'(bus_if.addr % (1 << DW));
        exp_drv = (pin_cmd() == 2) && (m_hold >= RL) && (bus_if.addr == m_last_addr) &&
                  !(bus_if.hb_mask && bus_if.lb_mask);
        check_eq({tag, "_drv"}, 32'(bus_if.rsp_drive), 32'(exp_drv));
        check_eq({tag, "_contend"}, 32'(bus_if.rsp_drive & bus_if.ctl_drive), 32'd0);
        if (exp_drv) begin
            known    = (bus_if.hb_mask || m_kh[idx]) && (bus_if.lb_mask || m_kl[idx]);
            exp_data = {bus_if.hb_mask ? 8'h00 : m_mem[idx][15:8],
                        bus_if.lb_mask ? 8'h00 : m_mem[idx][7:0]};
            if (known) check_eq({tag, "_data"}, 32'(bus_if.data), 32'(exp_data));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge();
        else       model_reset();
        #1;
    endtask

    task automatic drive_pins(input logic ce, input logic we, input logic oe,
                              input logic hb, input logic lb,
                              input logic [AW-1:0] a, input logic [15:0] wd);
        bus_if.chip_en   = ce;
        bus_if.wre       = we;
        bus_if.oute      = oe;
        bus_if.hb_mask   = hb;
        bus_if.lb_mask   = lb;
        bus_if.addr      = a;
        bus_if.ctl_wdata = wd;
        bus_if.ctl_drive = !ce && !we;
    endtask

    initial begin
        for (int i = 0; i < (1 << DW); i++) begin
            m_kh[i]  = 0;
            m_kl[i]  = 0;
            m_mem[i] = '0;
        end
        model_reset();
        drive_pins(1, 1, 1, 1, 1, '0, '0);
        #2;
        check_eq("rst_drv", 32'(bus_if.rsp_drive), 32'd0);
        tick();
        tick();
        check_eq("rst_hold_drv", 32'(bus_if.rsp_drive), 32'd0);
        reset = 1'b1;
        tick();
        check_eq("post_rst_drv", 32'(bus_if.rsp_drive), 32'd0);
        check_bus("post_rst");

        // full write then read
        drive_pins(0, 0, 1, 0, 0, 18'h00010, 16'hBEEF);
        tick(); check_bus("wr_beef");
        drive_pins(0, 1, 0, 0, 0, 18'h00010, '0);
        #1 check_eq("beef_e0_drv", 32'(bus_if.rsp_drive), 32'd0);
        tick(); check_eq("beef_e1_drv", 32'(bus_if.rsp_drive), 32'd0); check_bus("beef_e1");
        tick(); check_eq("beef_e2_drv", 32'(bus_if.rsp_drive), 32'd1);
        check_eq("beef_e2_data", 32'(bus_if.data), 32'h0000BEEF); check_bus("beef_e2");

        // byte lanes
        drive_pins(0, 0, 1, 0, 0, 18'd5, 16'h1234); tick(); check_bus("wr_1234");
        drive_pins(0, 0, 1, 0, 1, 18'd5, 16'hAB00); tick(); check_bus("wr_ab00");
        drive_pins(0, 0, 1, 0, 0, 18'd6, 16'h6666); tick(); check_bus("wr_6666");
        drive_pins(0, 1, 0, 0, 0, 18'd5, '0);
        tick(); check_bus("lane_e1");
        tick(); check_eq("lane_data", 32'(bus_if.data), 32'h0000AB34); check_bus("lane_e2");
        drive_pins(0, 1, 0, 0, 1, 18'd5, '0);
        #1 check_eq("lane_lbm", 32'(bus_if.data), 32'h0000AB00); check_bus("lane_lbm");
        drive_pins(0, 1, 0, 1, 1, 18'd5, '0);
        #1 check_eq("lane_both_drv", 32'(bus_if.rsp_drive), 32'd0);

        // address change restarts latency
        drive_pins(0, 1, 0, 0, 0, 18'd5, '0);
        #1 check_eq("chg_pre_drv", 32'(bus_if.rsp_drive), 32'd1);
        drive_pins(0, 1, 0, 0, 0, 18'd6, '0);
        #1 check_eq("chg_rel_drv", 32'(bus_if.rsp_drive), 32'd0);
        tick(); check_eq("chg_e1_drv", 32'(bus_if.rsp_drive), 32'd0);
        tick(); check_eq("chg_e2_data", 32'(bus_if.data), 32'h00006666); check_bus("chg_e2");

        // bus release then write without contention
        drive_pins(0, 1, 1, 0, 0, 18'd6, '0);
        #1 check_eq("rel_oute_drv", 32'(bus_if.rsp_drive), 32'd0);
        drive_pins(0, 0, 1, 0, 0, 18'd6, 16'h5555);
        #1 check_eq("rel_wr_bus", 32'(bus_if.data), 32'h00005555); check_bus("rel_wr");
        tick();
        drive_pins(0, 1, 0, 0, 0, 18'd6, '0);
        tick(); tick(); check_eq("rel_rd_data", 32'(bus_if.data), 32'h00005555); check_bus("rel_rd");

        // aliasing
        drive_pins(0, 0, 1, 0, 0, 18'h01003, 16'h00AA); tick();
        drive_pins(0, 1, 0, 0, 0, 18'd3, '0);
        tick(); tick(); check_eq("alias_data", 32'(bus_if.data), 32'h000000AA); check_bus("alias");

        // reset during a valid read
        reset = 1'b0;
        model_reset();
        #1 check_eq("midrst_drv", 32'(bus_if.rsp_drive), 32'd0);
        tick(); check_bus("midrst_hold");
        reset = 1'b1;
        tick(); check_eq("midrst_e1_drv", 32'(bus_if.rsp_drive), 32'd0);
        tick(); check_eq("midrst_e2_data", 32'(bus_if.data), 32'h000000AA); check_bus("midrst_e2");

        // randomized traffic over a few aliased words
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [AW-1:0] a;
            r = $urandom_range(0, 9);
            a = AW'(($urandom_range(0, 3) << DW) | $urandom_range(0, 7));
            drive_pins(r == 0, r >= 4 ? 1'b1 : 1'b0, r == 9,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       a, 16'($urandom));
            #1 check_bus("rnd_pre");
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                tick();
                check_bus("rnd");
            end
        end

        drive_pins(1, 1, 1, 1, 1, '0, '0);
        tick(); check_bus("final_idle");
`ifdef SRAM_ACCESS_CNT_EN
        check_eq("rd_count", rd_count, m_rd_cnt);
        check_eq("wr_count", wr_count, m_wr_cnt);
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
